// File: rtl/fg_cfg_pkg.sv
// Shared definitions for the function-generator SPI configuration loader:
// configuration-word layout, SPI command-byte fields and loader FSM states.
package fg_cfg_pkg;

  localparam int CFG_WIDTH = 64;

  // Command byte: bit7 requests a commit, bit6 selects read, bits[2:0] give the start byte.
  localparam int CMD_COMMIT_BIT = 7;
  localparam int CMD_READ_BIT   = 6;
  localparam int CMD_IDX_MSB    = 2;
  localparam int CMD_IDX_LSB    = 0;

  // Field map of CR_bus (MSB first): CS 63, MS 62, Radix 61, prescaler 60:52,
  // counter 51:42, phase/ON 41:32, rise 31:24, fall 23:16, amplitude 15:8, offset 7:0.
  typedef struct packed {
    logic       cs;
    logic       ms;
    logic       radix;
    logic [8:0] prescaler;
    logic [9:0] counter;
    logic [9:0] phase_on;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] amplitude;
    logic [7:0] offset;
  } cr_fields_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_READ
  } spi_state_e;

  function automatic int cfg_bytes(input int width);
    return width / 8;
  endfunction

  localparam int CFG_BYTES = cfg_bytes(CFG_WIDTH);

endpackage

// File: rtl/fg_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input with single-cycle
// rise/fall pulses detected against the previous synchronised value.
module fg_sync_edge #(
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_i};
    prev_d = sync_q[STAGES-1];
  end

  // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sync_q <= {STAGES{RESET_LEVEL}};
      prev_q <= RESET_LEVEL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o =  sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/fg_spi_config_loader.sv
// SPI mode-0 slave that assembles a shadow configuration word byte by byte and
// commits it atomically to CR_bus_o when commitEnable_i allows.
module fg_spi_config_loader
  import fg_cfg_pkg::*;
#(
  parameter int                             CONFIG_REG_BITWIDTH = CFG_WIDTH,
  parameter int                             SYNC_STAGES         = 2,
  parameter logic [CONFIG_REG_BITWIDTH-1:0] RESET_VALUE         = '0
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           spi_sclk_i,
  input  logic                           spi_csn_i,
  input  logic                           spi_mosi_i,
  output logic                           spi_miso_o,
  input  logic                           commitEnable_i,
  output logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o,
  output logic                           configUpdated_STRB_o,
  output logic                           frameError_o
);

  localparam int NBYTES = cfg_bytes(CONFIG_REG_BITWIDTH);
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef logic [IDX_W-1:0] idx_t;

  function automatic idx_t idx_inc(input idx_t idx);
    return (int'(idx) == NBYTES - 1) ? '0 : idx + 1'b1;
  endfunction

  logic sclk_rise, sclk_fall, csn_rise, csn_fall, mosi_s;

  fg_sync_edge #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (1'b0)
  ) u_sclk_sync (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .async_i (spi_sclk_i),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  // csn resets to the asserted level: a host still holding csn low after reset
  // yields no falling edge until it has released and reasserted the line.
  fg_sync_edge #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (1'b0)
  ) u_csn_sync (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .async_i (spi_csn_i),
    .rise_o  (csn_rise),
    .fall_o  (csn_fall)
  );

  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_seen_q, byte_seen_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       load_q, load_d;
  logic       commit_req_q, commit_req_d;
  idx_t       idx_q, idx_d;
  logic [7:0] shadow_q  [NBYTES];
  logic [7:0] shadow_d  [NBYTES];
  logic [7:0] pending_q [NBYTES];
  logic [7:0] pending_d [NBYTES];
  logic [7:0] cr_q      [NBYTES];
  logic [7:0] cr_d      [NBYTES];
  logic [7:0] reset_bytes [NBYTES];
  logic       pending_valid_q, pending_valid_d;
  logic       strobe_q, strobe_d;
  logic       frame_err_q, frame_err_d;
  logic       miso_q, miso_d;

  for (genvar g = 0; g < NBYTES; g++) begin : g_bytes
    assign reset_bytes[g]    = RESET_VALUE[g*8 +: 8];
    assign CR_bus_o[g*8 +: 8] = cr_q[g];
  end

  always_comb begin
    mosi_sync_d     = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    byte_seen_d     = byte_seen_q;
    rx_d            = rx_q;
    tx_d            = tx_q;
    load_d          = load_q;
    commit_req_d    = commit_req_q;
    idx_d           = idx_q;
    shadow_d        = shadow_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    cr_d            = cr_q;
    strobe_d        = 1'b0;
    frame_err_d     = frame_err_q;

    // The commit is evaluated first so a frame ending in the same cycle re-arms pending.
    if (pending_valid_q && commitEnable_i) begin
      cr_d            = pending_q;
      pending_valid_d = 1'b0;
      strobe_d        = 1'b1;
    end

    if (csn_fall) begin
      state_d      = ST_CMD;
      bit_cnt_d    = 3'd0;
      byte_seen_d  = 1'b0;
      commit_req_d = 1'b0;
      load_d       = 1'b0;
      tx_d         = 8'h00;
      frame_err_d  = 1'b0;
    end else if (state_q != ST_IDLE) begin
      if (sclk_rise) begin
        rx_d      = {rx_q[6:0], mosi_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_seen_d = 1'b1;
          unique case (state_q)
            ST_CMD: begin
              commit_req_d = rx_d[CMD_COMMIT_BIT];
              idx_d        = IDX_W'(int'(rx_d[CMD_IDX_MSB:CMD_IDX_LSB]) % NBYTES);
              if (rx_d[CMD_READ_BIT]) begin
                state_d = ST_READ;
                load_d  = 1'b1;
              end else begin
                state_d = ST_WRITE;
              end
            end
            ST_WRITE: begin
              shadow_d[idx_q] = rx_d;
              idx_d           = idx_inc(idx_q);
            end
            ST_READ: begin
              idx_d  = idx_inc(idx_q);
              load_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      if (sclk_fall && state_q == ST_READ) begin
        if (load_q) begin
          tx_d   = shadow_q[idx_q];
          load_d = 1'b0;
        end else begin
          tx_d = {tx_q[6:0], 1'b0};
        end
      end

      // End-of-frame checks look at the post-sclk values so a byte completing
      // in the same cycle as csn rising is written before it is judged.
      if (csn_rise) begin
        state_d = ST_IDLE;
        if (bit_cnt_d != 3'd0) begin
          frame_err_d = 1'b1;
        end else if (byte_seen_d && commit_req_d) begin
          pending_d       = shadow_d;
          pending_valid_d = 1'b1;
        end
      end
    end

    miso_d = (state_d == ST_READ) ? tx_d[7] : 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      mosi_sync_q     <= '0;
      state_q         <= ST_IDLE;
      bit_cnt_q       <= 3'd0;
      byte_seen_q     <= 1'b0;
      rx_q            <= 8'h00;
      tx_q            <= 8'h00;
      load_q          <= 1'b0;
      commit_req_q    <= 1'b0;
      idx_q           <= '0;
      // NOTE: these byte arrays are architectural registers with a defined reset value, so they are reset like any other flop.
      shadow_q        <= reset_bytes;
      pending_q       <= reset_bytes;
      cr_q            <= reset_bytes;
      pending_valid_q <= 1'b0;
      strobe_q        <= 1'b0;
      frame_err_q     <= 1'b0;
      miso_q          <= 1'b0;
    end else begin
      mosi_sync_q     <= mosi_sync_d;
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      byte_seen_q     <= byte_seen_d;
      rx_q            <= rx_d;
      tx_q            <= tx_d;
      load_q          <= load_d;
      commit_req_q    <= commit_req_d;
      idx_q           <= idx_d;
      shadow_q        <= shadow_d;
      pending_q       <= pending_d;
      cr_q            <= cr_d;
      pending_valid_q <= pending_valid_d;
      strobe_q        <= strobe_d;
      frame_err_q     <= frame_err_d;
      miso_q          <= miso_d;
    end
  end

  assign spi_miso_o           = miso_q;
  assign configUpdated_STRB_o = strobe_q;
  assign frameError_o         = frame_err_q;

endmodule

// File: tb/tb_fg_spi_config_loader.sv
// Randomised and directed SPI frames against a byte-array reference model;
// expected commits go to a scoreboard that a separate monitor drains on each strobe.
module tb_fg_spi_config_loader;

  localparam int W    = 64;
  localparam int SYNC = 2;
  localparam int HALF = 60;

  logic         clk_i     = 1'b0;
  logic         rstn_i    = 1'b0;
  logic         sclk      = 1'b0;
  logic         csn       = 1'b1;
  logic         mosi      = 1'b0;
  logic         commit_en = 1'b1;
  logic         miso;
  logic [W-1:0] cr;
  logic         strb;
  logic         ferr;

  fg_spi_config_loader #(
    .CONFIG_REG_BITWIDTH (W),
    .SYNC_STAGES         (SYNC),
    .RESET_VALUE         ('0)
  ) u_dut (
    .clk_i                (clk_i),
    .rstn_i               (rstn_i),
    .spi_sclk_i           (sclk),
    .spi_csn_i            (csn),
    .spi_mosi_i           (mosi),
    .spi_miso_o           (miso),
    .commitEnable_i       (commit_en),
    .CR_bus_o             (cr),
    .configUpdated_STRB_o (strb),
    .frameError_o         (ferr)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] cr;
    int          issue_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model: the configuration seen as eight plain bytes.
  logic [7:0]  m_shadow  [8];
  logic [7:0]  m_pending [8];
  bit          m_pv;
  bit          m_err;
  logic [63:0] m_cr;

  logic [7:0] tx_buf [16];
  logic [7:0] rx_buf [16];

  function automatic logic [63:0] pack(input logic [7:0] a [8]);
    logic [63:0] v;
    for (int b = 0; b < 8; b++) v[b*8 +: 8] = a[b];
    return v;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 8; b++) begin
      m_shadow[b]  = 8'h00;
      m_pending[b] = 8'h00;
    end
    m_pv  = 1'b0;
    m_err = 1'b0;
    m_cr  = '0;
  endtask

  task automatic model_end(input int nbits, input int rise_cyc);
    int         nby;
    int         idx;
    bit         part;
    logic [7:0] cmd;
    nby  = nbits / 8;
    part = (nbits % 8) != 0;
    cmd  = tx_buf[0];
    idx  = int'(cmd[2:0]);
    for (int b = 1; b < nby; b++) begin
      if (cmd[6]) check("read_byte", 64'(rx_buf[b]), 64'(m_shadow[idx]));
      else        m_shadow[idx] = tx_buf[b];
      idx = (idx + 1) % 8;
    end
    m_err = part;
    if (!part && nby >= 1 && cmd[7]) begin
      m_pending = m_shadow;
      m_pv      = 1'b1;
      if (commit_en) begin
        sb.push_back('{pack(m_pending), rise_cyc, SYNC + 2});
        m_cr = pack(m_pending);
        m_pv = 1'b0;
      end
    end
  endtask

  task automatic spi_frame(input int nbits, input bit fast_end);
    bit miso_or;
    bit is_read;
    int rise_cyc;
    miso_or = 1'b0;
    is_read = (nbits >= 8) && tx_buf[0][6];
    @(negedge clk_i);
    csn = 1'b0;
    #(HALF);
    check("err_clear_on_csn_fall", 64'(ferr), 64'd0);
    for (int i = 0; i < nbits; i++) begin
      mosi = tx_buf[i/8][7 - (i%8)];
      #(HALF);
      sclk = 1'b1;
      rx_buf[i/8][7 - (i%8)] = miso;
      if (i < 8 || !is_read) miso_or |= miso;
      if (fast_end && i == nbits - 1) break;
      #(HALF);
      sclk = 1'b0;
    end
    if (!fast_end) #(HALF);
    csn      = 1'b1;
    rise_cyc = cyc;
    model_end(nbits, rise_cyc);
    if (fast_end) begin
      #(HALF);
      sclk = 1'b0;
    end
    repeat (12) @(negedge clk_i);
    check("miso_zero_outside_read", 64'(miso_or), 64'd0);
    check("frame_error", 64'(ferr), 64'(m_err));
    check("cr_after_frame", cr, m_cr);
    check("missing_strobe", 64'(sb.size()), 64'd0);
  endtask

  task automatic commit_pulse();
    @(negedge clk_i);
    commit_en = 1'b1;
    if (m_pv) begin
      sb.push_back('{pack(m_pending), cyc, 1});
      m_cr = pack(m_pending);
      m_pv = 1'b0;
    end
    @(negedge clk_i);
    commit_en = 1'b0;
  endtask

  // Monitor: every strobe must match the oldest expected commit and its latency.
  initial begin
    forever begin
      @(negedge clk_i);
      if (strb === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got strobe with CR_bus_o=%h, expected no commit", cr);
        end else begin
          mon_e = sb.pop_front();
          check("commit_value", cr, mon_e.cr);
          check("commit_latency", 64'(cyc - mon_e.issue_cyc), 64'(mon_e.lat));
        end
      end
    end
  end

  initial begin
    int nby;
    int extra;
    model_reset();

    // Reset with csn high.
    repeat (3) @(negedge clk_i);
    check("reset_cr", cr, 64'd0);
    check("reset_miso", 64'(miso), 64'd0);
    check("reset_strobe", 64'(strb), 64'd0);
    check("reset_frame_error", 64'(ferr), 64'd0);
    rstn_i = 1'b1;
    repeat (5) @(negedge clk_i);

    // Full write with commit.
    tx_buf[0] = 8'h80;
    for (int b = 0; b < 8; b++) tx_buf[b+1] = 8'((b + 1) * 8'h11);
    spi_frame(72, 1'b0);
    check("full_write_cr", cr, 64'h8877665544332211);

    // Write without commit, read back, commit-only frame.
    tx_buf[0] = 8'h03; tx_buf[1] = 8'hAB;
    spi_frame(16, 1'b0);
    tx_buf[0] = 8'h43; tx_buf[1] = 8'h00;
    spi_frame(16, 1'b0);
    check("readback_0x43", 64'(rx_buf[1]), 64'hAB);
    tx_buf[0] = 8'h80;
    spi_frame(8, 1'b0);
    check("commit_only_byte3", 64'(cr[31:24]), 64'hAB);

    // Index wrap from byte 7 to byte 0.
    tx_buf[0] = 8'h87; tx_buf[1] = 8'hAA; tx_buf[2] = 8'hBB;
    spi_frame(24, 1'b0);
    check("wrap_byte7", 64'(cr[63:56]), 64'hAA);
    check("wrap_byte0", 64'(cr[7:0]), 64'hBB);

    // Partial byte: error, no commit; cleared by the next frame.
    tx_buf[0] = 8'h80; tx_buf[1] = 8'h5C;
    spi_frame(12, 1'b0);
    check("partial_sets_error", 64'(ferr), 64'd1);
    tx_buf[0] = 8'h00;
    spi_frame(8, 1'b0);

    // csn rising together with the completing 8th sclk edge.
    tx_buf[0] = 8'h85; tx_buf[1] = 8'h5A;
    spi_frame(16, 1'b1);
    check("same_cycle_end_byte5", 64'(cr[47:40]), 64'h5A);

    // Deferred commit: two frames, one enable pulse, one strobe.
    commit_en = 1'b0;
    tx_buf[0] = 8'h80; tx_buf[1] = 8'h01;
    spi_frame(16, 1'b0);
    tx_buf[1] = 8'h02;
    spi_frame(16, 1'b0);
    commit_pulse();
    repeat (10) @(negedge clk_i);
    check("deferred_byte0", 64'(cr[7:0]), 64'h02);
    check("deferred_drained", 64'(sb.size()), 64'd0);
    commit_en = 1'b1;

    // Random frames.
    for (int f = 0; f < 24; f++) begin
      nby   = int'($urandom_range(1, 9));
      extra = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 0;
      for (int b = 0; b < 16; b++) tx_buf[b] = 8'($urandom);
      spi_frame(nby * 8 + extra, $urandom_range(0, 4) == 0);
    end

    // Reset mid-frame, csn held low: nothing is accepted until csn toggles.
    @(negedge clk_i);
    csn = 1'b0;
    #(HALF);
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b1; #(HALF); sclk = 1'b1; #(HALF); sclk = 1'b0;
    end
    @(negedge clk_i);
    rstn_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    model_reset();
    tx_buf[0] = 8'h80;
    for (int i = 0; i < 8; i++) begin
      mosi = tx_buf[0][7 - i]; #(HALF); sclk = 1'b1; #(HALF); sclk = 1'b0;
    end
    #(HALF);
    csn = 1'b1;
    repeat (12) @(negedge clk_i);
    check("midframe_reset_cr", cr, 64'd0);
    check("midframe_reset_error", 64'(ferr), 64'd0);
    check("midframe_reset_miso", 64'(miso), 64'd0);

    repeat (20) @(negedge clk_i);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
